// File: rtl/ad9516_spi_responder.sv
// Behavioural SPI slave standing in for an AD9516 clock chip: decodes 24-bit frames,
// answers readback, and models the 0x018 -> 0x232 update and VCO-cal lock detect.
module ad9516_spi_responder #(
  parameter logic [7:0]  PART_ID    = 8'h41,
  parameter int unsigned LOCK_DELAY = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        frame_valid,
  output logic        frame_rw,
  output logic [12:0] frame_addr,
  output logic [7:0]  frame_data,
  output logic        frame_err,
  output logic [7:0]  frame_cnt,
  output logic        update_pulse,
  output logic        ld
);

  localparam logic [15:0] LP_LOCK = 16'(LOCK_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_INSTR, S_DATA, S_WAIT_CS} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cs_sync, r_sclk_sync, r_sdi_sync;
  logic        r_cs_d, r_sclk_d;
  logic        w_cs, w_sclk, w_sdi;
  logic        w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic        w_start, w_shift, w_instr_done, w_data_done, w_abort, w_extra;

  logic [4:0]  r_bitcnt;
  logic [14:0] r_shift;
  logic [15:0] r_instr;
  logic [15:0] w_instr;
  logic [7:0]  w_wdata, w_rdback;
  logic [7:0]  r_rd_byte, r_sdo_sr;
  logic        r_sdo_en, r_extra_seen;

  logic        r_frame_valid, r_frame_rw, r_frame_err, r_update, r_ld, r_cal_run;
  logic [12:0] r_frame_addr;
  logic [7:0]  r_frame_data, r_frame_cnt, r_reg18_buf, r_reg18_act;
  logic [15:0] r_cal_cnt;
  logic        w_unused_act;

  // Synchronizers plus one extra stage on cs_n/sclk for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_sync   <= 2'b11;
      r_sclk_sync <= 2'b00;
      r_sdi_sync  <= 2'b00;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], spi_cs_n};
      r_sclk_sync <= {r_sclk_sync[0], spi_sclk};
      r_sdi_sync  <= {r_sdi_sync[0], spi_sdi};
      r_cs_d      <= r_cs_sync[1];
      r_sclk_d    <= r_sclk_sync[1];
    end
  end

  assign w_cs        = r_cs_sync[1];
  assign w_sclk      = r_sclk_sync[1];
  assign w_sdi       = r_sdi_sync[1];
  assign w_cs_fall   = r_cs_d & ~w_cs;
  assign w_cs_rise   = ~r_cs_d & w_cs;
  assign w_sclk_rise = ~r_sclk_d & w_sclk & ~w_cs;
  assign w_sclk_fall = r_sclk_d & ~w_sclk & ~w_cs;

  assign w_instr = {r_shift[14:0], w_sdi};
  assign w_wdata = {r_shift[6:0], w_sdi};

  always_comb begin
    w_rdback = 8'h00;
    if (w_instr[12:0] == 13'h003)      w_rdback = PART_ID;
    else if (w_instr[12:0] == 13'h018) w_rdback = r_reg18_buf;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_instr_done = 1'b0;
    w_data_done  = 1'b0;
    w_abort      = 1'b0;
    w_extra      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = S_INSTR;
        end
      end
      S_INSTR: begin
        if (w_cs_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
          if (r_bitcnt == 5'd15) begin
            w_instr_done = 1'b1;
            w_state_nxt  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_cs_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
          if (r_bitcnt == 5'd23) begin
            w_data_done = 1'b1;
            w_state_nxt = S_WAIT_CS;
          end
        end
      end
      S_WAIT_CS: begin
        if (w_cs_rise)        w_state_nxt = S_IDLE;
        else if (w_sclk_rise) w_extra     = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitcnt      <= '0;
      r_shift       <= '0;
      r_instr       <= '0;
      r_rd_byte     <= '0;
      r_sdo_sr      <= '0;
      r_sdo_en      <= 1'b0;
      r_extra_seen  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_rw    <= 1'b0;
      r_frame_addr  <= '0;
      r_frame_data  <= '0;
      r_frame_err   <= 1'b0;
      r_frame_cnt   <= '0;
      r_update      <= 1'b0;
      r_reg18_buf   <= '0;
      r_reg18_act   <= '0;
      r_cal_cnt     <= '0;
      r_cal_run     <= 1'b0;
      r_ld          <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_update      <= 1'b0;

      if (r_cal_run) begin
        if (r_cal_cnt == 16'd0) begin
          r_ld      <= 1'b1;
          r_cal_run <= 1'b0;
        end else begin
          r_cal_cnt <= r_cal_cnt - 16'd1;
        end
      end

      if (w_start) begin
        r_bitcnt     <= '0;
        r_extra_seen <= 1'b0;
        r_sdo_en     <= 1'b0;
      end
      if (w_shift) begin
        r_shift  <= {r_shift[13:0], w_sdi};
        r_bitcnt <= r_bitcnt + 5'd1;
      end
      if (w_instr_done) begin
        r_instr   <= w_instr;
        r_rd_byte <= w_rdback;
        if (w_instr[15]) begin
          r_sdo_sr <= w_rdback;
          r_sdo_en <= 1'b1;
        end
      end
      // Hold the MSB through the falling edge that trails the last instruction bit,
      // so the master still sees it on the first data rising edge.
      if (r_sdo_en && r_state == S_DATA && w_sclk_fall && r_bitcnt != 5'd16)
        r_sdo_sr <= {r_sdo_sr[6:0], 1'b0};

      if (w_data_done) begin
        r_frame_valid <= 1'b1;
        r_frame_rw    <= r_instr[15];
        r_frame_addr  <= r_instr[12:0];
        r_frame_data  <= r_instr[15] ? r_rd_byte : w_wdata;
        r_frame_err   <= |r_instr[14:13];
        r_frame_cnt   <= r_frame_cnt + 8'd1;
        r_sdo_en      <= 1'b0;
        if (!r_instr[15]) begin
          if (r_instr[12:0] == 13'h018) r_reg18_buf <= w_wdata;
          if (r_instr[12:0] == 13'h232 && w_wdata[0]) begin
            r_reg18_act <= r_reg18_buf;
            r_update    <= 1'b1;
            if (!r_reg18_act[0] && r_reg18_buf[0]) begin
              r_cal_cnt <= LP_LOCK;
              r_cal_run <= 1'b1;
              r_ld      <= 1'b0;
            end
          end
        end
      end

      if (w_abort) begin
        r_frame_err <= 1'b1;
        r_sdo_en    <= 1'b0;
      end
      if (w_extra && !r_extra_seen) begin
        r_frame_err  <= 1'b1;
        r_extra_seen <= 1'b1;
      end
    end
  end

  assign w_unused_act = ^r_reg18_act[7:1];

  assign spi_sdo      = r_sdo_en & r_sdo_sr[7];
  assign frame_valid  = r_frame_valid;
  assign frame_rw     = r_frame_rw;
  assign frame_addr   = r_frame_addr;
  assign frame_data   = r_frame_data;
  assign frame_err    = r_frame_err;
  assign frame_cnt    = r_frame_cnt;
  assign update_pulse = r_update;
  assign ld           = r_ld;

endmodule

// File: tb/tb_ad9516_spi_responder.sv
// Bench for ad9516_spi_responder: fixed vector table, hand sequences for the
// update/cal and reset corners, and random frames against a frame-level model.
module tb_ad9516_spi_responder;
  localparam int          LD  = 20;
  localparam logic [7:0]  PID = 8'h41;

  logic        clk = 1'b0, rst = 1'b1;
  logic        spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_sdi = 1'b0;
  logic        spi_sdo, frame_valid, frame_rw, frame_err, update_pulse, ld;
  logic [12:0] frame_addr;
  logic [7:0]  frame_data, frame_cnt;

  always #5 clk = ~clk;

  ad9516_spi_responder #(.PART_ID(PID), .LOCK_DELAY(LD)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .frame_valid(frame_valid), .frame_rw(frame_rw),
    .frame_addr(frame_addr), .frame_data(frame_data), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .update_pulse(update_pulse), .ld(ld)
  );

  int n_cmp = 0, n_bad = 0;
  int g_half = 4;

  // Strobe monitor
  int          cyc = 0, n_valid = 0, n_err = 0, n_upd = 0, n_ldr = 0, upd_cyc = 0, ldr_cyc = 0;
  logic        m_rw = 1'b0, m_verr = 1'b0, ld_q = 1'b0;
  logic [12:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  always @(negedge clk) begin
    cyc++;
    if (frame_valid) begin
      n_valid++;
      m_rw = frame_rw; m_addr = frame_addr; m_data = frame_data; m_verr = frame_err;
    end
    if (frame_err) n_err++;
    if (update_pulse) begin n_upd++; upd_cyc = cyc; end
    if (ld && !ld_q) begin n_ldr++; ldr_cyc = cyc; end
    ld_q = ld;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_sdi = 1'b0;
    wt(4);
    rst = 1'b0;
    wt(4);
  endtask

  task automatic spi_bit(input logic b, output logic s);
    spi_sdi = b;
    wt(g_half);
    s = spi_sdo;
    spi_sclk = 1'b1;
    wt(g_half);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [23:0] w, input int nb, input int tail, output logic [7:0] rd);
    logic s;
    rd = '0;
    spi_cs_n = 1'b0;
    wt(g_half);
    for (int i = 0; i < nb; i++) begin
      spi_bit((i < 24) ? w[23-i] : 1'b1, s);
      if (i >= 16 && i < 24) rd[23-i] = s;
    end
    wt(g_half);
    spi_cs_n = 1'b1;
    wt(tail);
  endtask

  typedef struct {
    logic [23:0] w;
    int          nb;
    bit          v;
    bit          rw;
    logic [12:0] addr;
    logic [7:0]  data;
    int          de;
    logic [7:0]  cnt;
    logic [7:0]  rd;
  } vec_t;

  vec_t vt[9];

  // Frame-level model state
  logic [7:0] mb_buf, mb_act, mb_cnt;
  logic       mb_ld;

  initial begin
    logic [7:0]  rd;
    logic [23:0] w;
    int v0, e0, u0, r0, nb, sel, rsel;
    logic [12:0] a;
    logic [1:0]  wb;
    logic        rw;
    logic [7:0]  d, rb, expd;
    bit          upd;

    vt[0] = '{24'h00107C, 24, 1'b1, 1'b0, 13'h010, 8'h7C, 0, 8'd1, 8'h00};
    vt[1] = '{24'h800300, 24, 1'b1, 1'b1, 13'h003, 8'h41, 0, 8'd2, 8'h41};
    vt[2] = '{24'h001855, 10, 1'b0, 1'b0, 13'h000, 8'h00, 1, 8'd2, 8'h00};
    vt[3] = '{24'h001855, 24, 1'b1, 1'b0, 13'h018, 8'h55, 0, 8'd3, 8'h00};
    vt[4] = '{24'h801800, 24, 1'b1, 1'b1, 13'h018, 8'h55, 0, 8'd4, 8'h55};
    vt[5] = '{24'h20105A, 24, 1'b1, 1'b0, 13'h010, 8'h5A, 1, 8'd5, 8'h00};
    vt[6] = '{24'h0123AB, 28, 1'b1, 1'b0, 13'h123, 8'hAB, 1, 8'd6, 8'h00};
    vt[7] = '{24'h800400, 24, 1'b1, 1'b1, 13'h004, 8'h00, 0, 8'd7, 8'h00};
    vt[8] = '{24'h800000, 20, 1'b0, 1'b0, 13'h000, 8'h00, 1, 8'd7, 8'h00};

    // Reset state
    do_reset();
    chk("rst frame_cnt", 32'(frame_cnt), 0);
    chk("rst ld", 32'(ld), 0);
    chk("rst sdo", 32'(spi_sdo), 0);
    chk("rst valid", 32'(frame_valid), 0);
    chk("rst err", 32'(frame_err), 0);
    chk("rst addr", 32'(frame_addr), 0);
    chk("rst data", 32'(frame_data), 0);
    chk("rst upd", 32'(update_pulse), 0);

    // Vector table
    for (int k = 0; k < 9; k++) begin
      v0 = n_valid; e0 = n_err;
      spi_frame(vt[k].w, vt[k].nb, 30, rd);
      chk($sformatf("vec%0d valid", k), 32'(n_valid - v0), 32'(vt[k].v));
      chk($sformatf("vec%0d errs", k), 32'(n_err - e0), 32'(vt[k].de));
      chk($sformatf("vec%0d cnt", k), 32'(frame_cnt), 32'(vt[k].cnt));
      if (vt[k].v) begin
        chk($sformatf("vec%0d rw", k), 32'(m_rw), 32'(vt[k].rw));
        chk($sformatf("vec%0d addr", k), 32'(m_addr), 32'(vt[k].addr));
        chk($sformatf("vec%0d data", k), 32'(m_data), 32'(vt[k].data));
        chk($sformatf("vec%0d sdo", k), 32'(rd), 32'(vt[k].rd));
      end
    end
    chk("sdo idle", 32'(spi_sdo), 0);

    // Update / VCO cal sequence
    do_reset();
    u0 = n_upd;
    spi_frame(24'h001806, 24, 30, rd);
    spi_frame(24'h023201, 24, 30, rd);
    chk("cal upd1", 32'(n_upd - u0), 1);
    chk("cal ld after bit0=0", 32'(ld), 0);
    spi_frame(24'h001807, 24, 30, rd);
    chk("cal ld before upd2", 32'(ld), 0);
    r0 = n_ldr;
    spi_frame(24'h023201, 24, 30, rd);
    chk("cal upd2", 32'(n_upd - u0), 2);
    chk("cal ld rises once", 32'(n_ldr - r0), 1);
    chk("cal ld latency", 32'(ldr_cyc - upd_cyc), 32'(LD + 1));
    chk("cal ld high", 32'(ld), 1);

    // Random frames against the frame-level model
    do_reset();
    mb_buf = '0; mb_act = '0; mb_cnt = '0; mb_ld = 1'b0;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 3);
      a   = (sel == 0) ? 13'h003 : (sel == 1) ? 13'h018 : (sel == 2) ? 13'h232 : 13'($urandom);
      rw  = 1'($urandom_range(0, 1));
      wb  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      d   = 8'($urandom);
      w   = {rw, wb, a, d};
      rsel = $urandom_range(0, 9);
      nb  = (rsel < 8) ? 24 : (rsel == 8) ? $urandom_range(5, 23) : $urandom_range(25, 28);
      rb  = (a == 13'h003) ? PID : (a == 13'h018) ? mb_buf : 8'h00;
      expd = rw ? rb : d;
      upd = (nb >= 24) && !rw && (a == 13'h232) && d[0];
      if (nb >= 24) begin
        mb_cnt = mb_cnt + 8'd1;
        if (!rw && a == 13'h018) mb_buf = d;
        if (upd) begin
          if (!mb_act[0] && mb_buf[0]) mb_ld = 1'b1;
          mb_act = mb_buf;
        end
      end
      v0 = n_valid; e0 = n_err; u0 = n_upd;
      spi_frame(w, nb, 30, rd);
      chk($sformatf("rnd%0d valid", k), 32'(n_valid - v0), (nb >= 24) ? 1 : 0);
      chk($sformatf("rnd%0d errs", k), 32'(n_err - e0),
          (nb < 24) ? 1 : (((wb != 2'b00) ? 1 : 0) + ((nb > 24) ? 1 : 0)));
      chk($sformatf("rnd%0d upd", k), 32'(n_upd - u0), upd ? 1 : 0);
      chk($sformatf("rnd%0d cnt", k), 32'(frame_cnt), 32'(mb_cnt));
      chk($sformatf("rnd%0d ld", k), 32'(ld), 32'(mb_ld));
      if (nb >= 24) begin
        chk($sformatf("rnd%0d rw", k), 32'(m_rw), 32'(rw));
        chk($sformatf("rnd%0d addr", k), 32'(m_addr), 32'(a));
        chk($sformatf("rnd%0d data", k), 32'(m_data), 32'(expd));
        chk($sformatf("rnd%0d verr", k), 32'(m_verr), (wb != 2'b00) ? 1 : 0);
        chk($sformatf("rnd%0d sdo", k), 32'(rd), rw ? 32'(rb) : 0);
      end
    end

    // 70-frame configuration, then continue to 256 frames for the counter wrap
    do_reset();
    g_half = 3;
    v0 = n_valid; e0 = n_err; u0 = n_upd;
    for (int k = 0; k < 68; k++) spi_frame({3'b000, 13'(13'h0F0 + k), 8'(k * 3)}, 24, 6, rd);
    spi_frame(24'h001801, 24, 6, rd);
    spi_frame(24'h023201, 24, 6, rd);
    chk("cfg cnt", 32'(frame_cnt), 70);
    chk("cfg errs", 32'(n_err - e0), 0);
    chk("cfg upd", 32'(n_upd - u0), 1);
    chk("cfg ld still low", 32'(ld), 0);
    wt(LD);
    chk("cfg ld high", 32'(ld), 1);
    for (int k = 0; k < 186; k++) spi_frame({3'b000, 13'(13'h100 + k), 8'(k)}, 24, 6, rd);
    chk("wrap valid", 32'(n_valid - v0), 256);
    chk("wrap cnt", 32'(frame_cnt), 0);
    chk("wrap errs", 32'(n_err - e0), 0);

    // Reset during the third frame
    g_half = 4;
    spi_frame(24'h001811, 24, 30, rd);
    spi_frame(24'h0010AA, 24, 30, rd);
    e0 = n_err;
    spi_cs_n = 1'b0;
    wt(g_half);
    w = 24'h023201;
    for (int i = 0; i < 12; i++) spi_bit(w[23-i], rd[0]);
    rst = 1'b1;
    wt(2);
    spi_cs_n = 1'b1;
    wt(3);
    rst = 1'b0;
    wt(4);
    chk("mrst cnt", 32'(frame_cnt), 0);
    chk("mrst ld", 32'(ld), 0);
    chk("mrst addr", 32'(frame_addr), 0);
    chk("mrst data", 32'(frame_data), 0);
    chk("mrst rw", 32'(frame_rw), 0);
    chk("mrst sdo", 32'(spi_sdo), 0);
    chk("mrst no err", 32'(n_err - e0), 0);
    v0 = n_valid;
    spi_frame(24'h801800, 24, 30, rd);
    chk("mrst next valid", 32'(n_valid - v0), 1);
    chk("mrst next rw", 32'(m_rw), 1);
    chk("mrst next addr", 32'(m_addr), 32'h018);
    chk("mrst next data", 32'(m_data), 0);
    chk("mrst next cnt", 32'(frame_cnt), 1);
    chk("mrst next errs", 32'(n_err - e0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
